// File: rtl/micro_bitos_pkg.sv
// Shared definitions for the micro_bitos core: opcodes, MATH and JMP codes,
// instruction field positions and the jump-condition helper.
package micro_bitos_pkg;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 4;
  localparam int RY_MSB = 3;
  localparam int RY_LSB = 2;
  localparam int FN_MSB = 1;
  localparam int FN_LSB = 0;
  localparam int SUB_MSB = 3;
  localparam int SUB_LSB = 0;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_LOAD      = 3'b001,
    OP_STORE_IMM = 3'b010,
    OP_STORE_IND = 3'b011,
    OP_MOVE      = 3'b100,
    OP_MATH      = 3'b101,
    OP_JMP       = 3'b110,
    OP_NOP_ALT   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    MOP_INC = 4'b0000,
    MOP_DEC = 4'b0001,
    MOP_NOT = 4'b0010,
    MOP_SHL = 4'b0011,
    MOP_SHR = 4'b0100,
    MOP_NEG = 4'b0101,
    MOP_CLR = 4'b0110,
    MOP_ADD = 4'b0111
  } math_op_e;

  typedef enum logic [3:0] {
    COND_Z   = 4'b0001,
    COND_NZ  = 4'b0010,
    COND_C   = 4'b0011,
    COND_NC  = 4'b0100,
    COND_ALW = 4'b1111
  } cond_e;

  function automatic logic cond_met(input logic [3:0] cond, input logic z, input logic c);
    logic met;
    case (cond_e'(cond))
      COND_Z:   met = z;
      COND_NZ:  met = ~z;
      COND_C:   met = c;
      COND_NC:  met = ~c;
      COND_ALW: met = 1'b1;
      default:  met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/micro_bitos_alu.sv
// Combinational MATH unit. Shift ops exist only when MICROBITOS_SHIFT_EN is
// defined; otherwise they fall into the reserved (no write) group.
module micro_bitos_alu
  import micro_bitos_pkg::*;
(
  input  logic [7:0] rx_i,
  input  logic [7:0] r0_i,
  input  logic [3:0] op_i,
  output logic [7:0] result_o,
  output logic       z_o,
  output logic       c_o,
  output logic       we_o
);

  logic [7:0] result_s;
  logic       c_s;
  logic       we_s;

  // Result, carry and write-enable selection per MATH sub-op
  always_comb begin
    result_s = rx_i;
    c_s      = 1'b0;
    we_s     = 1'b1;
    case (math_op_e'(op_i))
      MOP_INC: {c_s, result_s} = {1'b0, rx_i} + 9'd1;
      MOP_DEC: begin
        result_s = rx_i - 8'd1;
        c_s      = (rx_i == 8'd0);
      end
      MOP_NOT: result_s = ~rx_i;
`ifdef MICROBITOS_SHIFT_EN
      MOP_SHL: begin
        result_s = {rx_i[6:0], 1'b0};
        c_s      = rx_i[7];
      end
      MOP_SHR: begin
        result_s = {1'b0, rx_i[7:1]};
        c_s      = rx_i[0];
      end
`endif
      MOP_NEG: begin
        result_s = 8'd0 - rx_i;
        c_s      = (rx_i != 8'd0);
      end
      MOP_CLR: result_s = 8'd0;
      MOP_ADD: {c_s, result_s} = {1'b0, rx_i} + {1'b0, r0_i};
      default: we_s = 1'b0;
    endcase
  end

  assign result_o = result_s;
  assign z_o      = (result_s == 8'd0);
  assign c_o      = c_s;
  assign we_o     = we_s;

endmodule

// File: rtl/micro_bitos.sv
// micro_bitos: single-cycle 8-bit Harvard core with four registers.
// Optional shifter enabled by defining MICROBITOS_SHIFT_EN.
module micro_bitos
  import micro_bitos_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] i_Instruccion,
  input  logic [7:0] i_DataIn_Bus,
  output logic       W_R,
  output logic [7:0] o_DataOut_Bus,
  output logic [7:0] o_Address_Instruction_Bus,
  output logic [7:0] o_Address_Data_Bus
);

  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic [7:0] pc_q, pc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;

  opcode_e    op_s;
  logic [1:0] rx_idx_s, ry_idx_s, fn_s;
  logic [3:0] sub_s;
  logic [7:0] rx_val_s, ry_val_s;
  logic [7:0] alu_res_s;
  logic       alu_z_s, alu_c_s, alu_we_s;
  logic       wr_s;
  logic [7:0] addr_s, dout_s;

  assign op_s     = opcode_e'(i_Instruccion[OP_MSB:OP_LSB]);
  assign rx_idx_s = i_Instruccion[RX_MSB:RX_LSB];
  assign ry_idx_s = i_Instruccion[RY_MSB:RY_LSB];
  assign fn_s     = i_Instruccion[FN_MSB:FN_LSB];
  assign sub_s    = i_Instruccion[SUB_MSB:SUB_LSB];
  assign rx_val_s = regs_q[rx_idx_s];
  assign ry_val_s = regs_q[ry_idx_s];

  micro_bitos_alu u_alu (
    .rx_i     (rx_val_s),
    .r0_i     (regs_q[0]),
    .op_i     (sub_s),
    .result_o (alu_res_s),
    .z_o      (alu_z_s),
    .c_o      (alu_c_s),
    .we_o     (alu_we_s)
  );

  // Decode: next architectural state and raw bus values
  always_comb begin
    pc_d   = pc_q + 8'd1;
    regs_d = regs_q;
    z_d    = z_q;
    c_d    = c_q;
    wr_s   = 1'b0;
    addr_s = 8'd0;
    dout_s = 8'd0;
    case (op_s)
      OP_LOAD: begin
        if (fn_s[1]) begin
          addr_s = ry_val_s;
        end else begin
          addr_s = {5'd0, ry_idx_s, fn_s[0]};
        end
        regs_d[rx_idx_s] = i_DataIn_Bus;
      end
      OP_STORE_IMM: begin
        addr_s = {4'd0, sub_s};
        dout_s = rx_val_s;
        wr_s   = 1'b1;
      end
      OP_STORE_IND: begin
        addr_s = rx_val_s;
        dout_s = ry_val_s;
        wr_s   = 1'b1;
      end
      OP_MOVE: regs_d[rx_idx_s] = ry_val_s;
      OP_MATH: begin
        if (alu_we_s) begin
          regs_d[rx_idx_s] = alu_res_s;
          z_d              = alu_z_s;
          c_d              = alu_c_s;
        end else begin
          z_d = z_q;
        end
      end
      OP_JMP: begin
        if (cond_met(sub_s, z_q, c_q)) begin
          pc_d = rx_val_s;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      default: pc_d = pc_q + 8'd1;
    endcase
  end

  // Buses are forced quiet while reset is held, independent of the fetched word
  always_comb begin
    if (!reset) begin
      W_R                = 1'b0;
      o_DataOut_Bus      = 8'd0;
      o_Address_Data_Bus = 8'd0;
    end else begin
      W_R                = wr_s;
      o_DataOut_Bus      = dout_s;
      o_Address_Data_Bus = addr_s;
    end
  end

  assign o_Address_Instruction_Bus = pc_q;

  // Architectural state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 8'd0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      pc_q   <= pc_d;
      z_q    <= z_d;
      c_q    <= c_d;
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_micro_bitos.sv
// Scoreboard bench for micro_bitos: directed instruction stream, expected bus
// values queued by the driver and checked by an independent monitor.
module tb_micro_bitos;

  logic       clk;
  logic       reset;
  logic [8:0] instr;
  logic [7:0] din;
  logic       w_r;
  logic [7:0] dout, addr_i, addr_d;

  typedef struct packed {
    logic [7:0] pc;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] dout;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef MICROBITOS_SHIFT_EN
  localparam logic [7:0] PC_C23 = 8'h04;
  localparam logic [7:0] PC_C24 = 8'h04;
  localparam logic [7:0] R1_SHL = 8'h02;
  localparam logic [7:0] R1_NEG = 8'hFE;
  localparam logic [7:0] R1_ADD = 8'h1E;
`else
  localparam logic [7:0] PC_C23 = 8'h0A;
  localparam logic [7:0] PC_C24 = 8'h0B;
  localparam logic [7:0] R1_SHL = 8'h81;
  localparam logic [7:0] R1_NEG = 8'h7F;
  localparam logic [7:0] R1_ADD = 8'h9F;
`endif

  micro_bitos dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_Instruccion             (instr),
    .i_DataIn_Bus              (din),
    .W_R                       (w_r),
    .o_DataOut_Bus             (dout),
    .o_Address_Instruction_Bus (addr_i),
    .o_Address_Data_Bus        (addr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp("pc", addr_i, e.pc);
      cmp("w_r", {7'd0, w_r}, {7'd0, e.wr});
      cmp("daddr", addr_d, e.addr);
      cmp("dout", dout, e.dout);
    end
  end

  task automatic step(input logic r, input logic [8:0] ins, input logic [7:0] d,
                      input logic [7:0] pc, input logic wr, input logic [7:0] a,
                      input logic [7:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r;
    instr = ins;
    din   = d;
    e.pc = pc; e.wr = wr; e.addr = a; e.dout = o;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    instr = 9'h1FF;
    din   = 8'h00;
    // reset held: buses quiet even with a store presented
    step(1'b0, 9'h1FF,       8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b0, 9'b011101100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b000000000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b001101000, 8'h04, 8'h01, 1'b0, 8'h04, 8'h00);
    step(1'b1, 9'b001101010, 8'h04, 8'h02, 1'b0, 8'h04, 8'h00);
    step(1'b1, 9'b010101011, 8'h00, 8'h03, 1'b1, 8'h0B, 8'h04);
    step(1'b1, 9'b011101100, 8'h00, 8'h04, 1'b1, 8'h04, 8'h00);
    step(1'b1, 9'b100101001, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b001000001, 8'hFF, 8'h06, 1'b0, 8'h01, 8'h00);
    step(1'b1, 9'b010000000, 8'h00, 8'h07, 1'b1, 8'h00, 8'hFF);
    step(1'b1, 9'b101000000, 8'h00, 8'h08, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010000001, 8'h00, 8'h09, 1'b1, 8'h01, 8'h00);
    // flag-conditional jumps to R2=0x04
    step(1'b1, 9'b110100001, 8'h00, 8'h0A, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100010, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100100, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100011, 8'h00, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100101, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b101001000, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100001, 8'h00, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010000010, 8'h00, 8'h04, 1'b1, 8'h02, 8'h00);
    // shift group, result depends on build configuration
    step(1'b1, 9'b001010101, 8'h81, 8'h05, 1'b0, 8'h03, 8'h00);
    step(1'b1, 9'b101110110, 8'h00, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b101010011, 8'h00, 8'h07, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010010101, 8'h00, 8'h08, 1'b1, 8'h05, R1_SHL);
    step(1'b1, 9'b110100011, 8'h00, 8'h09, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100010, 8'h00, PC_C23, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110101111, 8'h00, PC_C24, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b101110001, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010110110, 8'h00, 8'h05, 1'b1, 8'h06, 8'hFF);
    step(1'b1, 9'b101110010, 8'h00, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110100100, 8'h00, 8'h07, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b101010101, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010010111, 8'h00, 8'h05, 1'b1, 8'h07, R1_NEG);
    step(1'b1, 9'b001001010, 8'h90, 8'h06, 1'b0, 8'h04, 8'h00);
    step(1'b1, 9'b101000111, 8'h00, 8'h07, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010001000, 8'h00, 8'h08, 1'b1, 8'h08, 8'h20);
    step(1'b1, 9'b110100011, 8'h00, 8'h09, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b101010111, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b011100100, 8'h00, 8'h05, 1'b1, 8'h04, R1_ADD);
    step(1'b1, 9'b100110100, 8'h00, 8'h06, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b010111001, 8'h00, 8'h07, 1'b1, 8'h09, R1_ADD);
    // PC wrap through 0xFF
    step(1'b1, 9'b001110000, 8'hFE, 8'h08, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b110111111, 8'h00, 8'h09, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b000000000, 8'h00, 8'hFE, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b111000000, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b000000000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b000000000, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00);
    // asynchronous reset in the middle of a store
    step(1'b0, 9'b010101011, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b0, 9'b011101100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b000000000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 9'b011101100, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
